// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for the M stage with byte/half/word access
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LAT         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall_o,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misalign_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  count;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_f3;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] mem_idx;
    logic [31:0]   word;
    logic [1:0]    lane;
    logic          is_byte;
    logic          is_half;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_data;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          misal;
    logic          last;
    logic          commit;

    always_comb begin
        mem_idx = AW'(lat_addr[31:2] % 30'(DEPTH_WORDS));
        word    = mem[mem_idx];
        lane    = lat_addr[1:0];
        // Loads use funct3[2] as the unsigned flag; stores treat every non-sb/sh code as a word.
        is_byte = (lat_f3[1:0] == 2'b00) && (!lat_we || !lat_f3[2]);
        is_half = (lat_f3[1:0] == 2'b01) && (!lat_we || !lat_f3[2]);
        byte_v  = word[{lane, 3'b000} +: 8];
        half_v  = lat_addr[1] ? word[31:16] : word[15:0];

        load_data = word;
        be        = 4'b1111;
        wd        = lat_wdata;
        if (is_byte) begin
            load_data = lat_f3[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            be        = 4'b0001 << lane;
            wd        = {4{lat_wdata[7:0]}};
        end else if (is_half) begin
            load_data = lat_f3[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            be        = lat_addr[1] ? 4'b1100 : 4'b0011;
            wd        = {2{lat_wdata[15:0]}};
        end

`ifdef DMEM_MISALIGN_CHK_EN
        misal = (is_half && lat_addr[0]) || (!is_byte && !is_half && (lat_addr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
    end

    assign last   = (state == WAIT) && (count == 4'd0);
    assign commit = last && lat_we && !misal;

    // Gated by rst so the pipeline is released the moment reset is asserted.
    assign stall_o = rst && (((state == IDLE) && req_valid) || (state == WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_f3     <= 3'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            misalign_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_f3    <= req_funct3;
                        count     <= 4'(LAT - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state      <= DONE;
                        rsp_valid  <= 1'b1;
                        misalign_o <= misal;
                        rsp_rdata  <= (lat_we || misal) ? 32'd0 : load_data;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    rsp_valid  <= 1'b0;
                    misalign_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array has no reset; a store only lands on the last WAIT edge.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[mem_idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

endmodule
